// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and width defaults for the data-RAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 16;

    // Arbiter sequencing states; 2'b11 is unused and falls back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Which requester owns the access currently in flight.
    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection between CPU and host, with a bounded host starvation counter.
// Latency: grant_host is combinational; wait_cnt updates on the arbitration edge.
// Backpressure: none; the counter only moves when arb_en marks a real arbitration.
module dmem_arb_select
    import dmem_arbiter_pkg::*;
#(
    parameter int HOST_MAX_WAIT = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic cpu_req,
    input  logic host_req,
    output logic grant_host
);

    localparam int               CNT_W   = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(HOST_MAX_WAIT);

    // Number of contended arbitrations the host has lost since its last grant.
    logic [CNT_W-1:0] wait_cnt;

    // Host wins when alone, or when it has lost enough contended rounds.
    always_comb begin
        grant_host = host_req & (~cpu_req | (wait_cnt == MAX_CNT));
    end

    // Clear on any host grant, count contended CPU wins, never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (arb_en) begin
            if (grant_host) begin
                wait_cnt <= '0;
            end else if (cpu_req && host_req && (wait_cnt != MAX_CNT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and the host port.
// Latency: 3 cycles from request seen in IDLE to ack (IDLE, ACCESS, RESP); 1 access per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; cpu_stall holds the PC meanwhile.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int HOST_MAX_WAIT = 4
)
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_wen,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   cmd_load;
    logic   cmd_clr;
    logic   grant_host;

    dmem_arb_select #(
        .HOST_MAX_WAIT (HOST_MAX_WAIT)
    ) u_sel (
        .clk        (CLK),
        .reset      (RESET),
        .arb_en     (cmd_load),
        .cpu_req    (cpu_req),
        .host_req   (host_req),
        .grant_host (grant_host)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus command load/clear strobes; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        cmd_load  = 1'b0;
        cmd_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req || host_req) begin
                    state_nxt = ST_ACCESS;
                    cmd_load  = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_RESP;
                cmd_clr   = 1'b1;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // RAM command and owner registers; write enable lives only for the ACCESS cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner    <= OWN_CPU;
            ram_wen  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (cmd_load) begin
            owner    <= grant_host ? OWN_HOST : OWN_CPU;
            ram_wen  <= grant_host ? host_wen   : cpu_wen;
            ram_addr <= grant_host ? host_addr  : cpu_addr;
            ram_din  <= grant_host ? host_wdata : cpu_wdata;
        end else if (cmd_clr) begin
            ram_wen  <= 1'b0;
        end
    end

    // Acks depend only on registered state so no req-to-ack combinational path exists.
    always_comb begin
        cpu_ack    = (state == ST_RESP) && (owner == OWN_CPU);
        host_ack   = (state == ST_RESP) && (owner == OWN_HOST);
        cpu_rdata  = ram_dout;
        host_rdata = ram_dout;
        cpu_stall  = cpu_req & ~cpu_ack;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a transaction-level model.
// Latency: checks ack timing and data on every cycle.
// Backpressure: requesters hold req until ack, as the handshake requires.
module tb_dmem_arbiter;

    localparam int HMW = 4;

    logic        CLK;
    logic        RESET;
    logic        cpu_req, cpu_wen, host_req, host_wen;
    logic [6:0]  cpu_addr, host_addr;
    logic [15:0] cpu_wdata, host_wdata;
    logic        cpu_ack, host_ack, cpu_stall, ram_wen;
    logic [15:0] cpu_rdata, host_rdata, ram_din, ram_dout;
    logic [6:0]  ram_addr;

    // Second instance with HOST_MAX_WAIT=0.
    logic        z_cpu_req, z_host_req, z_wen;
    logic [6:0]  z_addr;
    logic [15:0] z_wdata, z_ram_dout;
    logic        z_cpu_ack, z_host_ack, z_cpu_stall, z_ram_wen;
    logic [15:0] z_cpu_rdata, z_host_rdata, z_ram_din;
    logic [6:0]  z_ram_addr;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(16), .HOST_MAX_WAIT(HMW)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    dmem_arbiter #(.ADDR_W(7), .DATA_W(16), .HOST_MAX_WAIT(0)) dut_z (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(z_cpu_req), .cpu_wen(z_wen), .cpu_addr(z_addr), .cpu_wdata(z_wdata),
        .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
        .host_req(z_host_req), .host_wen(z_wen), .host_addr(z_addr), .host_wdata(z_wdata),
        .host_ack(z_host_ack), .host_rdata(z_host_rdata),
        .ram_wen(z_ram_wen), .ram_addr(z_ram_addr), .ram_din(z_ram_din), .ram_dout(z_ram_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_val(input int i);
        if (i == 127) return 16'h1234;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // RAM primitive: 1-cycle synchronous read, preloaded on the first edge.
    logic [15:0] mem [128];
    bit          loaded = 1'b0;
    always @(posedge CLK) begin
        if (!loaded) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_wen) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    // Reference model: one transaction at a time, aged in cycles since its grant.
    logic [15:0] ref_mem [128];
    bit          m_pend, m_host, m_wen;
    int          m_age, m_wait;
    logic [6:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;
    bit          e_cpu_ack, e_host_ack, e_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic model_step();
        if (RESET) begin
            if (m_pend && m_age == 1 && m_wen) ref_mem[m_addr] = m_wdata;
            m_pend = 0; m_age = 0; m_wait = 0;
        end else if (!m_pend) begin
            if (cpu_req || host_req) begin
                m_host = host_req && (!cpu_req || m_wait >= HMW);
                if (m_host) m_wait = 0;
                else if (host_req && m_wait < HMW) m_wait++;
                m_wen   = m_host ? host_wen   : cpu_wen;
                m_addr  = m_host ? host_addr  : cpu_addr;
                m_wdata = m_host ? host_wdata : cpu_wdata;
                m_pend  = 1; m_age = 1;
            end
        end else if (m_age == 1) begin
            if (m_wen) ref_mem[m_addr] = m_wdata;
            else       m_rdata = ref_mem[m_addr];
            m_age = 2;
        end else begin
            m_pend = 0; m_age = 0;
        end
        e_acc      = m_pend && m_age == 1;
        e_cpu_ack  = m_pend && m_age == 2 && !m_host;
        e_host_ack = m_pend && m_age == 2 && m_host;
    endtask

    // One clock: model, edge, then compare outputs 1 time unit later.
    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
        check("cpu_ack",   32'(cpu_ack),   32'(e_cpu_ack));
        check("host_ack",  32'(host_ack),  32'(e_host_ack));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cpu_ack));
        check("ram_wen",   32'(ram_wen),   32'(e_acc && m_wen));
        check("wait_cnt",  32'(dut.u_sel.wait_cnt), 32'(m_wait));
        if (e_acc) begin
            check("ram_addr", 32'(ram_addr), 32'(m_addr));
            if (m_wen) check("ram_din", 32'(ram_din), 32'(m_wdata));
        end
        if ((e_cpu_ack || e_host_ack) && !m_wen)
            check("rdata", 32'(e_cpu_ack ? cpu_rdata : host_rdata), 32'(m_rdata));
    endtask

    task automatic new_cpu();
        cpu_req = 1; cpu_wen = 1'($urandom_range(0, 1));
        cpu_addr = 7'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
    endtask

    task automatic new_host();
        host_req = 1; host_wen = 1'($urandom_range(0, 1));
        host_addr = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
        host_wdata = 16'($urandom);
    endtask

    initial begin
        int         n, g, hcnt, ccnt;
        bit         cseen;
        logic [9:0] order;

        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        m_pend = 0; m_age = 0; m_wait = 0; m_host = 0; m_wen = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        RESET = 1;
        cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_wen = 0; host_addr = '0; host_wdata = '0;
        z_cpu_req = 0; z_host_req = 0; z_wen = 0; z_addr = '0; z_wdata = '0; z_ram_dout = '0;

        // Reset state.
        repeat (3) cyc();
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_din",  32'(ram_din),  32'h0);
        check("rst_z_acks",   32'({z_cpu_ack, z_host_ack}), 32'h0);
        RESET = 0;
        cyc();

        // CPU write from IDLE: ACCESS after 1 edge, ack after 2.
        cpu_req = 1; cpu_wen = 1; cpu_addr = 7'h05; cpu_wdata = 16'hBEEF;
        cyc();
        check("wr_ram_wen_c2", 32'(ram_wen), 32'h1);
        cyc();
        check("wr_ack_c3", 32'(cpu_ack), 32'h1);
        check("wr_ram_wen_c3", 32'(ram_wen), 32'h0);

        // Back-to-back read of the same word, presented at the ack edge.
        cpu_wen = 0;
        n = 0;
        do begin cyc(); n++; end while (!cpu_ack && n < 8);
        check("rd_latency", 32'(n), 32'd3);
        check("rd_beef", 32'(cpu_rdata), 32'hBEEF);

        // Host-only read of the preloaded top word.
        cpu_req = 0;
        host_req = 1; host_wen = 0; host_addr = 7'h7F;
        n = 0; cseen = 0;
        do begin cyc(); n++; cseen |= cpu_ack; end while (!host_ack && n < 8);
        check("host_rd_latency", 32'(n), 32'd3);
        check("host_rd_1234", 32'(host_rdata), 32'h1234);
        check("host_rd_no_cpu_ack", 32'(cseen), 32'h0);
        host_req = 0;

        // Idle: nothing happens.
        repeat (4) cyc();
        check("idle_ram_wen", 32'(ram_wen), 32'h0);

        // Stall profile for a CPU read from IDLE.
        cpu_req = 1; cpu_wen = 0; cpu_addr = 7'h03;
        #1;
        check("stall_idle", 32'(cpu_stall), 32'h1);
        cyc();
        check("stall_access", 32'(cpu_stall), 32'h1);
        cyc();
        check("stall_ack", 32'(cpu_stall), 32'h0);
        check("stall_ack_pulse", 32'(cpu_ack), 32'h1);
        cpu_req = 0;
        cyc();

        // Reset in the ACCESS cycle of a write: no ack, RAM still takes the write.
        cpu_req = 1; cpu_wen = 1; cpu_addr = 7'h10; cpu_wdata = 16'h00AA;
        cyc();
        check("rst_mid_access", 32'(ram_wen), 32'h1);
        RESET = 1;
        cyc();
        check("rst_mid_no_ack", 32'(cpu_ack), 32'h0);
        check("rst_mid_wen", 32'(ram_wen), 32'h0);
        RESET = 0; cpu_req = 0;
        cyc();
        check("rst_mid_no_ack2", 32'(cpu_ack), 32'h0);
        cpu_req = 1; cpu_wen = 0; cpu_addr = 7'h10;
        n = 0;
        do begin cyc(); n++; end while (!cpu_ack && n < 8);
        check("rst_mid_latency", 32'(n), 32'd2);
        check("rst_mid_data", 32'(cpu_rdata), 32'h00AA);
        cpu_req = 0;

        // Continuous contention: host wins every fifth grant.
        RESET = 1; cyc(); RESET = 0;
        cpu_req = 1; cpu_wen = 0; cpu_addr = 7'h01;
        host_req = 1; host_wen = 0; host_addr = 7'h02;
        order = 10'b1000010000;
        g = 0;
        for (int c = 0; c < 40 && g < 10; c++) begin
            cyc();
            if (cpu_ack || host_ack) begin
                check("grant_order", 32'(host_ack), 32'(order[g]));
                if (host_ack) check("wait_after_host", 32'(dut.u_sel.wait_cnt), 32'h0);
                g++;
            end
        end
        check("grant_count", 32'(g), 32'd10);
        cpu_req = 0; host_req = 0;
        RESET = 1; cyc(); RESET = 0;

        // HOST_MAX_WAIT=0: host wins every contention; CPU only when host drops.
        z_cpu_req = 1; z_host_req = 1;
        hcnt = 0; ccnt = 0;
        for (int c = 0; c < 20 && hcnt < 4; c++) begin
            cyc();
            hcnt += int'(z_host_ack);
            ccnt += int'(z_cpu_ack);
        end
        check("z_host_wins", 32'(hcnt), 32'd4);
        check("z_cpu_starved", 32'(ccnt), 32'd0);
        z_host_req = 0;
        n = 0;
        do begin cyc(); n++; end while (!z_cpu_ack && n < 8);
        check("z_cpu_after_host", 32'(n), 32'd3);
        z_cpu_req = 0;

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            RESET = ($urandom_range(0, 99) == 0);
            cyc();
            if (!cpu_req) begin
                if ($urandom_range(0, 3) == 0) new_cpu();
            end else if (cpu_ack) begin
                if ($urandom_range(0, 1) == 0) cpu_req = 0; else new_cpu();
            end
            if (!host_req) begin
                if ($urandom_range(0, 3) == 0) new_host();
            end else if (host_ack) begin
                if ($urandom_range(0, 1) == 0) host_req = 0; else new_host();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 128x16 data RAM between the CPU load/store path and a host/debug port (program loader, memory inspector).
- Sits between the CPU datapath (R1[6:0] address, R2 write data, RAMWEN, RAMOUT) and the RAM primitive, which has a 1-cycle synchronous read.
- Sequences every access through a 3-state FSM, with fixed CPU priority and a starvation bound for the host.
- Exports a stall to hold the PC while a CPU access is pending.

Parameters:
ADDR_W, 7, RAM address width
DATA_W, 16, RAM data width
HOST_MAX_WAIT, 4, number of contended arbitrations the host may lose before it is forced to win (0 = host wins every contention)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_wen  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid when cpu_ack
cpu_stall  out  1  cpu_req & ~cpu_ack, gates PC LOAD and REGWEN
host_req  in  1  host access request, level, held until host_ack
host_wen  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  read data, valid when host_ack
ram_wen  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_din  out  DATA_W  RAM write data (registered)
ram_dout  in  DATA_W  RAM read data, valid 1 cycle after address sampled

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state registers update only on the rising edge of CLK.
- Reset values: state=IDLE, owner=CPU, wait_cnt=0, ram_wen=0, ram_addr=0, ram_din=0. Hence cpu_ack=0 and host_ack=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Any request: select a winner, register ram_addr, ram_din, ram_wen and owner from the winner, then go to ACCESS.
- Winner selection in IDLE:
  - Only one requester: that requester wins.
  - Both requesting, wait_cnt < HOST_MAX_WAIT: CPU wins and wait_cnt increments.
  - Both requesting, wait_cnt == HOST_MAX_WAIT: host wins.
  - wait_cnt clears to 0 whenever the host is granted.
  - wait_cnt is unchanged when the CPU wins uncontended. It saturates and never wraps.
- ACCESS:
  - The RAM samples ram_addr, ram_wen and ram_din on the closing edge of this cycle.
  - At that edge ram_wen clears to 0 and the FSM goes to RESP.
  - ram_wen is high only during ACCESS cycles.
- RESP:
  - The ack of the owner is 1 for exactly this cycle.
  - {owner}_rdata = ram_dout for both reads and writes; the value is don't-care on writes.
  - Next state is IDLE.
  - The rdata of the non-owner is also ram_dout but carries no meaning without its ack.
- Acks are decoded from state and owner only; there is no combinational path from req to ack.
- Latency: req sampled in IDLE, then ACCESS, then ack in RESP, i.e. 3 cycles. Peak throughput is 1 access per 3 cycles.
- Handshake rules:
  - A requester keeps req, wen, addr and wdata stable until it samples ack=1.
  - At that edge the requester either drops req or presents a new transaction.
  - A req still high in the IDLE cycle after RESP is treated as a new transaction.
- Simultaneous events: a request arriving during ACCESS or RESP waits. It is arbitrated in the next IDLE cycle.
- Reset mid-operation:
  - Reset during ACCESS: the RAM still samples the registered command at that edge, so a write may complete, but no ack is issued. The requester must reissue.
  - Reset during RESP: the ack is suppressed from the following cycle onward.
- Address and data are passed unchanged; widths match, so no truncation or extension is applied.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10; 2'b11 is illegal and recovers to IDLE
  - owner encoding: OWN_CPU=1'b0, OWN_HOST=1'b1
  - ADDR_W and DATA_W defaults
- One natural sub-module, dmem_arb_select. It is combinational winner logic (cpu_req, host_req, wait_cnt → grant_host) plus the wait_cnt register with its saturate/clear rules.
- The FSM and RAM command registers stay in the top.

Test Plan:
- Reset, then CPU write: cpu_req=1, wen=1, addr=7'h05, wdata=16'hBEEF → ram_wen=1 only in cycle 2, cpu_ack pulses in cycle 3. A following CPU read of 7'h05 returns cpu_rdata=16'hBEEF with cpu_ack.
- Host-only read: host_req=1, addr=7'h7F, preloaded 16'h1234 → host_ack in cycle 3 with host_rdata=16'h1234, cpu_ack stays 0 throughout.
- Contention: cpu_req and host_req held continuously with HOST_MAX_WAIT=4 → grant order C,C,C,C,H,C,C,C,C,H, and wait_cnt reads 0 after each host grant.
- HOST_MAX_WAIT=0, both requesting → host wins every contended arbitration, and the CPU is granted only when host_req=0.
- Stall: CPU read pending → cpu_stall=1 for 2 cycles, 0 in the ack cycle. With idle requests, ram_wen=0 and the FSM stays in IDLE.
- RESET=1 asserted in the ACCESS cycle of a CPU write to 7'h10 with 16'h00AA → no cpu_ack, state=IDLE the next cycle, ram_wen=0, and the RAM location may hold 16'h00AA.
